tag_lookup_2port: RTL and testbench

- Lookup stage directly upstream of the 2-read/1-write synchronous tag memory.
- Serves two channels:
  - core channel: read or write to tag/state array;
  - snoop channel: read only.
- Drives the memory's A port (core) and B port (snoop), and captures the 1-cycle-latency read data.
- Compares tags and returns hit/state responses through per-channel valid/ready response queues.
- Enforces the memory rule: a cycle carries either 2 reads or 1 write, never a write plus a snoop read.

---
 rtl/tag_lookup_2port_if.sv | 45 ++++
 rtl/tag_lookup_2port.sv | 172 +++++++++++++++++
 tb/tb_tag_lookup_2port.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tag_lookup_2port_if.sv
// Request/response bundle for tag_lookup_2port: the core channel (read or
// write) and the snoop channel (read only). Each channel has a valid/ready
// request side and a valid/ready response side.
// The slave modport is the lookup stage; the master modport is the requester.
interface tag_lookup_2port_if #(
  parameter int els_p         = 64,
  parameter int tag_width_p   = 20,
  parameter int state_width_p = 2
);
  localparam int addr_width_lp = $clog2(els_p);

  logic                     core_v_i;
  logic                     core_ready_o;
  logic                     core_w_i;
  logic [addr_width_lp-1:0] core_index_i;
  logic [tag_width_p-1:0]   core_tag_i;
  logic [state_width_p-1:0] core_state_i;
  logic                     core_resp_v_o;
  logic                     core_resp_ready_i;
  logic                     core_hit_o;
  logic [state_width_p-1:0] core_state_o;

  logic                     snoop_v_i;
  logic                     snoop_ready_o;
  logic [addr_width_lp-1:0] snoop_index_i;
  logic [tag_width_p-1:0]   snoop_tag_i;
  logic                     snoop_resp_v_o;
  logic                     snoop_resp_ready_i;
  logic                     snoop_hit_o;
  logic [state_width_p-1:0] snoop_state_o;

  modport master (
    output core_v_i, core_w_i, core_index_i, core_tag_i, core_state_i, core_resp_ready_i,
    input  core_ready_o, core_resp_v_o, core_hit_o, core_state_o,
    output snoop_v_i, snoop_index_i, snoop_tag_i, snoop_resp_ready_i,
    input  snoop_ready_o, snoop_resp_v_o, snoop_hit_o, snoop_state_o
  );

  modport slave (
    input  core_v_i, core_w_i, core_index_i, core_tag_i, core_state_i, core_resp_ready_i,
    output core_ready_o, core_resp_v_o, core_hit_o, core_state_o,
    input  snoop_v_i, snoop_index_i, snoop_tag_i, snoop_resp_ready_i,
    output snoop_ready_o, snoop_resp_v_o, snoop_hit_o, snoop_state_o
  );
endinterface

// File: rtl/tag_lookup_2port.sv
// Lookup stage in front of a 2-read/1-write synchronous tag memory.
// Core channel drives memory port A (read or write), snoop channel drives
// port B (read only). Read data arrives one cycle after the request; the
// tag compare happens then and {hit, state} is pushed into a 2-entry
// per-channel response FIFO, so a response is visible two cycles after accept.
// A core write owns the cycle: the snoop channel is held off so the memory
// never sees a write together with a second read.
// Optional build macro: TAG_LOOKUP_CHECK_EN enables concurrent assertions.
//
// Channel arrays below use index 0 = core, 1 = snoop.
module tag_lookup_2port #(
  parameter int els_p         = 64,
  parameter int tag_width_p   = 20,
  parameter int state_width_p = 2,
  localparam int addr_width_lp = $clog2(els_p),
  localparam int word_width_lp = state_width_p + tag_width_p
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  tag_lookup_2port_if.slave        req_if,
  output logic                     mem_a_v_o,
  output logic                     mem_a_w_o,
  output logic [addr_width_lp-1:0] mem_a_addr_o,
  output logic [word_width_lp-1:0] mem_a_data_o,
  input  logic [word_width_lp-1:0] mem_a_data_i,
  output logic                     mem_b_v_o,
  output logic [addr_width_lp-1:0] mem_b_addr_o,
  input  logic [word_width_lp-1:0] mem_b_data_i
);
  localparam int entry_width_lp = 1 + state_width_p;

  // in-flight read (issued last cycle) and the tag it is looking for
  logic [1:0]                s1_v_q, s1_v_d;
  logic [tag_width_p-1:0]    s1_tag_q [2];
  logic [tag_width_p-1:0]    s1_tag_d [2];

  // response FIFOs of {hit, state}
  logic [entry_width_lp-1:0] fifo_q [2][2];
  logic [entry_width_lp-1:0] fifo_d [2][2];
  logic [1:0]                rd_ptr_q, rd_ptr_d;
  logic [1:0]                wr_ptr_q, wr_ptr_d;
  logic [1:0]                count_q [2];
  logic [1:0]                count_d [2];

  logic [1:0]                push, pop, credit, rd_acc, resp_ready, resp_v;
  logic [word_width_lp-1:0]  rdata [2];
  logic [tag_width_p-1:0]    req_tag [2];
  logic [1:0]                lookup_hit;
  logic [state_width_p-1:0]  lookup_state [2];
  logic [entry_width_lp-1:0] head [2];
  logic                      core_wr_acc;
  logic                      snoop_ready;

  // Credit per channel: at most one read may be outstanding beyond what
  // the FIFO can still absorb after this cycle's pop.
  always_comb begin
    resp_ready = {req_if.snoop_resp_ready_i, req_if.core_resp_ready_i};
    for (int ch = 0; ch < 2; ch++) begin
      resp_v[ch] = (count_q[ch] != 2'd0);
      pop[ch]    = resp_v[ch] & resp_ready[ch];
      push[ch]   = s1_v_q[ch];
      credit[ch] = (({1'b0, s1_v_q[ch]} + count_q[ch] - {1'b0, pop[ch]}) <= 2'd1);
    end
  end

  // Request handshakes; an accepted core write blocks the snoop read.
  always_comb begin
    core_wr_acc = req_if.core_v_i & req_if.core_w_i & credit[0];
    snoop_ready = credit[1] & ~core_wr_acc;
    rd_acc[0]   = req_if.core_v_i & ~req_if.core_w_i & credit[0];
    rd_acc[1]   = req_if.snoop_v_i & snoop_ready;
    req_tag[0]  = req_if.core_tag_i;
    req_tag[1]  = req_if.snoop_tag_i;
    rdata[0]    = mem_a_data_i;
    rdata[1]    = mem_b_data_i;
  end

  assign req_if.core_ready_o  = credit[0];
  assign req_if.snoop_ready_o = snoop_ready;

  assign mem_a_v_o    = req_if.core_v_i & credit[0];
  assign mem_a_w_o    = req_if.core_w_i;
  assign mem_a_addr_o = req_if.core_index_i;
  assign mem_a_data_o = {req_if.core_state_i, req_if.core_tag_i};
  assign mem_b_v_o    = rd_acc[1];
  assign mem_b_addr_o = req_if.snoop_index_i;

  // Tag compare on the word returned for last cycle's read.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      lookup_state[ch] = rdata[ch][word_width_lp-1 -: state_width_p];
      lookup_hit[ch]   = (rdata[ch][tag_width_p-1:0] == s1_tag_q[ch]) &&
                         (lookup_state[ch] != '0);
    end
  end

  // Next state: launch reads, push compare results, advance FIFO pointers.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      s1_v_d[ch]    = rd_acc[ch];
      s1_tag_d[ch]  = rd_acc[ch] ? req_tag[ch] : s1_tag_q[ch];
      fifo_d[ch][0] = fifo_q[ch][0];
      fifo_d[ch][1] = fifo_q[ch][1];
      if (push[ch]) begin
        fifo_d[ch][wr_ptr_q[ch]] = {lookup_hit[ch], lookup_state[ch]};
      end
      wr_ptr_d[ch] = wr_ptr_q[ch] ^ push[ch];
      rd_ptr_d[ch] = rd_ptr_q[ch] ^ pop[ch];
      count_d[ch]  = count_q[ch] + {1'b0, push[ch]} - {1'b0, pop[ch]};
    end
  end

  // Response outputs from the FIFO head, forced to zero while empty.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      head[ch] = resp_v[ch] ? fifo_q[ch][rd_ptr_q[ch]] : '0;
    end
  end

  assign req_if.core_resp_v_o  = resp_v[0];
  assign req_if.core_hit_o     = head[0][state_width_p];
  assign req_if.core_state_o   = head[0][state_width_p-1:0];
  assign req_if.snoop_resp_v_o = resp_v[1];
  assign req_if.snoop_hit_o    = head[1][state_width_p];
  assign req_if.snoop_state_o  = head[1][state_width_p-1:0];

  // State registers; reset discards in-flight reads and queued responses.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_v_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int ch = 0; ch < 2; ch++) begin
        s1_tag_q[ch]  <= '0;
        count_q[ch]   <= '0;
        fifo_q[ch][0] <= '0;
        fifo_q[ch][1] <= '0;
      end
    end else begin
      s1_v_q   <= s1_v_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      for (int ch = 0; ch < 2; ch++) begin
        s1_tag_q[ch]  <= s1_tag_d[ch];
        count_q[ch]   <= count_d[ch];
        fifo_q[ch][0] <= fifo_d[ch][0];
        fifo_q[ch][1] <= fifo_d[ch][1];
      end
    end
  end

`ifdef TAG_LOOKUP_CHECK_EN
  a_write_excludes_snoop: assert property (@(posedge clk_i) disable iff (reset_i)
    (mem_a_v_o && mem_a_w_o) |-> !mem_b_v_o)
    else $error("tag_lookup_2port: write issued together with snoop read");

  a_mem_v_known: assert property (@(posedge clk_i) disable iff (reset_i)
    !$isunknown({mem_a_v_o, mem_b_v_o}))
    else $error("tag_lookup_2port: X on memory valid");

  for (genvar ch = 0; ch < 2; ch++) begin : g_chk
    a_no_push_full: assert property (@(posedge clk_i) disable iff (reset_i)
      push[ch] |-> (count_q[ch] != 2'd2))
      else $error("tag_lookup_2port: response FIFO %0d pushed while full", ch);

    a_resp_stable: assert property (@(posedge clk_i) disable iff (reset_i)
      (resp_v[ch] && !resp_ready[ch]) |=> $stable(head[ch]))
      else $error("tag_lookup_2port: response %0d changed while stalled", ch);
  end
`endif

endmodule

// File: tb/tb_tag_lookup_2port.sv
`timescale 1ns/1ps
module tb_tag_lookup_2port;
  localparam int ELS = 64;
  localparam int TW  = 20;
  localparam int SW  = 2;
  localparam int AW  = 6;
  localparam int WW  = SW + TW;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  tag_lookup_2port_if #(.els_p(ELS), .tag_width_p(TW), .state_width_p(SW)) bus ();

  logic          mem_a_v_o, mem_a_w_o, mem_b_v_o;
  logic [AW-1:0] mem_a_addr_o, mem_b_addr_o;
  logic [WW-1:0] mem_a_data_o, mem_a_rd, mem_b_rd;

  tag_lookup_2port #(.els_p(ELS), .tag_width_p(TW), .state_width_p(SW)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .req_if       (bus),
    .mem_a_v_o    (mem_a_v_o),
    .mem_a_w_o    (mem_a_w_o),
    .mem_a_addr_o (mem_a_addr_o),
    .mem_a_data_o (mem_a_data_o),
    .mem_a_data_i (mem_a_rd),
    .mem_b_v_o    (mem_b_v_o),
    .mem_b_addr_o (mem_b_addr_o),
    .mem_b_data_i (mem_b_rd)
  );

  // synchronous 2R/1W tag memory, 1-cycle read latency
  logic [WW-1:0] mem_arr [ELS];
  logic          mem_clear;
  always @(posedge clk_i) begin
    if (mem_clear) begin
      for (int i = 0; i < ELS; i++) mem_arr[i] <= '0;
      mem_a_rd <= '0;
      mem_b_rd <= '0;
    end else begin
      if (mem_a_v_o && mem_a_w_o) mem_arr[mem_a_addr_o] <= mem_a_data_o;
      else if (mem_a_v_o)         mem_a_rd <= mem_arr[mem_a_addr_o];
      if (mem_b_v_o)              mem_b_rd <= mem_arr[mem_b_addr_o];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  logic [TW-1:0] bt_tag [16];
  logic [SW-1:0] bt_st  [16];

  task automatic drive(input logic cv, input logic cw, input logic [AW-1:0] ci,
                       input logic [TW-1:0] ct, input logic [SW-1:0] cs,
                       input logic sv, input logic [AW-1:0] si, input logic [TW-1:0] st,
                       input logic crr, input logic srr);
    @(negedge clk_i);
    bus.core_v_i = cv;  bus.core_w_i = cw;  bus.core_index_i = ci;
    bus.core_tag_i = ct; bus.core_state_i = cs;
    bus.snoop_v_i = sv; bus.snoop_index_i = si; bus.snoop_tag_i = st;
    bus.core_resp_ready_i = crr; bus.snoop_resp_ready_i = srr;
    #1;
  endtask

  task automatic idle(input logic crr, input logic srr);
    drive(0, 0, '0, '0, '0, 0, '0, '0, crr, srr);
  endtask

  task automatic do_reset();
    bus.core_v_i = 0; bus.core_w_i = 0; bus.core_index_i = '0; bus.core_tag_i = '0;
    bus.core_state_i = '0; bus.snoop_v_i = 0; bus.snoop_index_i = '0; bus.snoop_tag_i = '0;
    bus.core_resp_ready_i = 1; bus.snoop_resp_ready_i = 1;
    reset_i = 1; mem_clear = 1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 0; mem_clear = 0;
  endtask

  function automatic logic hit_of(input logic [WW-1:0] w, input logic [TW-1:0] t);
    return (w[TW-1:0] == t) && (w[WW-1:TW] != '0);
  endfunction

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++; if (bus.core_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_core_ready got %b want 1", bus.core_ready_o); end
    n_vec++; if (bus.snoop_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_snoop_ready got %b want 1", bus.snoop_ready_o); end
    n_vec++; if ({bus.core_resp_v_o, bus.snoop_resp_v_o} !== 2'b00) begin n_err++; $display("FAIL rst_resp_v got %b want 00", {bus.core_resp_v_o, bus.snoop_resp_v_o}); end
    n_vec++; if ({bus.core_hit_o, bus.core_state_o, bus.snoop_hit_o, bus.snoop_state_o} !== 6'd0) begin n_err++; $display("FAIL rst_payload got %b want 0", {bus.core_hit_o, bus.core_state_o, bus.snoop_hit_o, bus.snoop_state_o}); end
  endtask

  task automatic test_write_read();
    drive(1, 1, 6'd5, 20'hABCDE, 2'd2, 0, '0, '0, 1, 1);
    n_vec++; if ({mem_a_v_o, mem_a_w_o, mem_b_v_o} !== 3'b110) begin n_err++; $display("FAIL wr_mem_ctl got %b want 110", {mem_a_v_o, mem_a_w_o, mem_b_v_o}); end
    n_vec++; if (mem_a_data_o !== {2'd2, 20'hABCDE} || mem_a_addr_o !== 6'd5) begin n_err++; $display("FAIL wr_mem_data got %h@%0d want %h@5", mem_a_data_o, mem_a_addr_o, {2'd2, 20'hABCDE}); end
    drive(1, 0, 6'd5, 20'hABCDE, 2'd0, 0, '0, '0, 1, 1);
    n_vec++; if ({bus.core_ready_o, mem_a_v_o, mem_a_w_o} !== 3'b110) begin n_err++; $display("FAIL rd_accept got %b want 110", {bus.core_ready_o, mem_a_v_o, mem_a_w_o}); end
    idle(1, 1);
    n_vec++; if (bus.core_resp_v_o !== 1'b0) begin n_err++; $display("FAIL rd_early_resp got %b want 0", bus.core_resp_v_o); end
    idle(1, 1);
    n_vec++; if ({bus.core_resp_v_o, bus.core_hit_o, bus.core_state_o} !== 4'b1_1_10) begin n_err++; $display("FAIL rd_hit_resp got %b want 1110", {bus.core_resp_v_o, bus.core_hit_o, bus.core_state_o}); end
    idle(1, 1);
    n_vec++; if (bus.core_resp_v_o !== 1'b0) begin n_err++; $display("FAIL rd_resp_popped got %b want 0", bus.core_resp_v_o); end
  endtask

  task automatic test_miss_and_unwritten();
    drive(1, 0, 6'd5, 20'h12345, 2'd0, 1, 6'd9, 20'h00000, 1, 1);
    n_vec++; if ({bus.core_ready_o, bus.snoop_ready_o, mem_a_v_o, mem_b_v_o} !== 4'b1111) begin n_err++; $display("FAIL dual_accept got %b want 1111", {bus.core_ready_o, bus.snoop_ready_o, mem_a_v_o, mem_b_v_o}); end
    idle(1, 1);
    idle(1, 1);
    n_vec++; if ({bus.core_resp_v_o, bus.core_hit_o, bus.core_state_o} !== 4'b1_0_10) begin n_err++; $display("FAIL core_miss got %b want 1010", {bus.core_resp_v_o, bus.core_hit_o, bus.core_state_o}); end
    n_vec++; if ({bus.snoop_resp_v_o, bus.snoop_hit_o, bus.snoop_state_o} !== 4'b1_0_00) begin n_err++; $display("FAIL snoop_unwritten got %b want 1000", {bus.snoop_resp_v_o, bus.snoop_hit_o, bus.snoop_state_o}); end
  endtask

  task automatic test_write_snoop_conflict();
    drive(1, 1, 6'd7, 20'h55555, 2'd1, 1, 6'd7, 20'h55555, 1, 1);
    n_vec++; if ({bus.core_ready_o, mem_a_v_o, bus.snoop_ready_o, mem_b_v_o} !== 4'b1100) begin n_err++; $display("FAIL wr_blocks_snoop got %b want 1100", {bus.core_ready_o, mem_a_v_o, bus.snoop_ready_o, mem_b_v_o}); end
    drive(0, 0, '0, '0, '0, 1, 6'd7, 20'h55555, 1, 1);
    n_vec++; if ({bus.snoop_ready_o, mem_b_v_o, mem_a_v_o} !== 3'b110) begin n_err++; $display("FAIL snoop_retry got %b want 110", {bus.snoop_ready_o, mem_b_v_o, mem_a_v_o}); end
    idle(1, 1);
    n_vec++; if (bus.snoop_resp_v_o !== 1'b0) begin n_err++; $display("FAIL snoop_early_resp got %b want 0", bus.snoop_resp_v_o); end
    idle(1, 1);
    n_vec++; if ({bus.snoop_resp_v_o, bus.snoop_hit_o, bus.snoop_state_o} !== 4'b1_1_01) begin n_err++; $display("FAIL snoop_new_data got %b want 1101", {bus.snoop_resp_v_o, bus.snoop_hit_o, bus.snoop_state_o}); end
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] rtag [16];
    logic          ehit [16];
    for (int i = 0; i < 16; i++) begin
      bt_tag[i] = TW'($urandom);
      bt_st[i]  = SW'($urandom);
      rtag[i]   = ($urandom % 2 == 0) ? bt_tag[i] : (bt_tag[i] ^ TW'(1 << (i % TW)));
      ehit[i]   = (rtag[i] == bt_tag[i]) && (bt_st[i] != '0);
      drive(1, 1, AW'(i), bt_tag[i], bt_st[i], 0, '0, '0, 1, 1);
    end
    for (int c = 0; c < 18; c++) begin
      if (c < 16) drive(1, 0, AW'(c), rtag[c], '0, 0, '0, '0, 1, 1);
      else        idle(1, 1);
      if (c < 16) begin
        n_vec++; if (bus.core_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d] got %b want 1", c, bus.core_ready_o); end
      end
      if (c >= 2) begin
        n_vec++; if ({bus.core_resp_v_o, bus.core_hit_o, bus.core_state_o} !== {1'b1, ehit[c-2], bt_st[c-2]}) begin
          n_err++; $display("FAIL b2b_resp[%0d] got %b want %b", c - 2, {bus.core_resp_v_o, bus.core_hit_o, bus.core_state_o}, {1'b1, ehit[c-2], bt_st[c-2]});
        end
      end else begin
        n_vec++; if (bus.core_resp_v_o !== 1'b0) begin n_err++; $display("FAIL b2b_early[%0d] got %b want 0", c, bus.core_resp_v_o); end
      end
    end
    idle(1, 1);
    n_vec++; if (bus.core_resp_v_o !== 1'b0) begin n_err++; $display("FAIL b2b_drained got %b want 0", bus.core_resp_v_o); end
  endtask

  task automatic test_backpressure();
    logic [2:0] exp [3];
    for (int i = 0; i < 3; i++) exp[i] = {bt_st[i] != '0, bt_st[i]};
    drive(1, 0, 6'd0, bt_tag[0], '0, 0, '0, '0, 0, 1);
    n_vec++; if (bus.core_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_acc0 got %b want 1", bus.core_ready_o); end
    drive(1, 0, 6'd1, bt_tag[1], '0, 0, '0, '0, 0, 1);
    n_vec++; if (bus.core_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_acc1 got %b want 1", bus.core_ready_o); end
    for (int c = 2; c < 5; c++) begin
      drive(1, 0, 6'd2, bt_tag[2], '0, 0, '0, '0, 0, 1);
      n_vec++; if ({bus.core_ready_o, mem_a_v_o} !== 2'b00) begin n_err++; $display("FAIL bp_stall[%0d] got %b want 00", c, {bus.core_ready_o, mem_a_v_o}); end
      n_vec++; if ({bus.core_resp_v_o, bus.core_hit_o, bus.core_state_o} !== {1'b1, exp[0]}) begin n_err++; $display("FAIL bp_head_hold[%0d] got %b want %b", c, {bus.core_resp_v_o, bus.core_hit_o, bus.core_state_o}, {1'b1, exp[0]}); end
    end
    drive(1, 0, 6'd2, bt_tag[2], '0, 0, '0, '0, 1, 1);
    n_vec++; if (bus.core_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", bus.core_ready_o); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) idle(1, 1);
      n_vec++; if ({bus.core_resp_v_o, bus.core_hit_o, bus.core_state_o} !== {1'b1, exp[k]}) begin n_err++; $display("FAIL bp_drain[%0d] got %b want %b", k, {bus.core_resp_v_o, bus.core_hit_o, bus.core_state_o}, {1'b1, exp[k]}); end
    end
    idle(1, 1);
    n_vec++; if (bus.core_resp_v_o !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b want 0", bus.core_resp_v_o); end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 6'd0, bt_tag[0], '0, 0, '0, '0, 0, 0);
    drive(1, 0, 6'd1, bt_tag[1], '0, 0, '0, '0, 0, 0);
    idle(0, 0);
    drive(0, 0, '0, '0, '0, 1, 6'd3, bt_tag[3], 0, 0);
    idle(0, 0);
    n_vec++; if (bus.core_resp_v_o !== 1'b1) begin n_err++; $display("FAIL ar_queued got %b want 1", bus.core_resp_v_o); end
    #1 reset_i = 1;
    #1;
    n_vec++; if ({bus.core_resp_v_o, bus.snoop_resp_v_o} !== 2'b00) begin n_err++; $display("FAIL ar_drop got %b want 00", {bus.core_resp_v_o, bus.snoop_resp_v_o}); end
    n_vec++; if ({bus.core_hit_o, bus.core_state_o} !== 3'd0) begin n_err++; $display("FAIL ar_payload got %b want 000", {bus.core_hit_o, bus.core_state_o}); end
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 0;
    for (int c = 0; c < 4; c++) begin
      idle(1, 1);
      n_vec++; if ({bus.core_resp_v_o, bus.snoop_resp_v_o, bus.core_ready_o, bus.snoop_ready_o} !== 4'b0011) begin
        n_err++; $display("FAIL ar_no_stale[%0d] got %b want 0011", c, {bus.core_resp_v_o, bus.snoop_resp_v_o, bus.core_ready_o, bus.snoop_ready_o});
      end
    end
  endtask

  typedef struct { logic hit; logic [SW-1:0] st; int due; } resp_t;

  task automatic test_random();
    resp_t         cq[$], sq[$], e;
    logic [WW-1:0] ref_mem [ELS];
    logic cv, cw, sv, crr, srr, exp_cv, exp_sv, cpop, spop, exp_cr, exp_sr, c_acc, s_acc;
    logic [AW-1:0] ci, si;
    logic [TW-1:0] ct, st;
    logic [SW-1:0] cs;
    do_reset();
    for (int i = 0; i < ELS; i++) ref_mem[i] = '0;
    for (int cyc = 0; cyc < 406; cyc++) begin
      cv = ($urandom % 4 != 0); cw = ($urandom % 4 == 0); ci = AW'($urandom % 8);
      ct = TW'($urandom % 3); cs = SW'($urandom);
      sv = ($urandom % 3 != 0); si = AW'($urandom % 8); st = TW'($urandom % 3);
      crr = ($urandom % 4 != 0); srr = ($urandom % 4 != 0);
      if (cyc >= 400) begin cv = 0; sv = 0; crr = 1; srr = 1; end
      drive(cv, cw, ci, ct, cs, sv, si, st, crr, srr);
      exp_cv = (cq.size() > 0) && (cq[0].due <= cyc);
      exp_sv = (sq.size() > 0) && (sq[0].due <= cyc);
      cpop   = exp_cv && crr;
      spop   = exp_sv && srr;
      exp_cr = ((cq.size() - int'(cpop)) <= 1);
      c_acc  = cv && exp_cr;
      exp_sr = ((sq.size() - int'(spop)) <= 1) && !(c_acc && cw);
      s_acc  = sv && exp_sr;
      n_vec++; if ({bus.core_ready_o, bus.snoop_ready_o} !== {exp_cr, exp_sr}) begin n_err++; $display("FAIL rnd_ready[%0d] got %b want %b", cyc, {bus.core_ready_o, bus.snoop_ready_o}, {exp_cr, exp_sr}); end
      n_vec++; if ({mem_a_v_o, mem_b_v_o} !== {c_acc, s_acc}) begin n_err++; $display("FAIL rnd_mem_v[%0d] got %b want %b", cyc, {mem_a_v_o, mem_b_v_o}, {c_acc, s_acc}); end
      n_vec++; if ({bus.core_resp_v_o, bus.snoop_resp_v_o} !== {exp_cv, exp_sv}) begin n_err++; $display("FAIL rnd_resp_v[%0d] got %b want %b", cyc, {bus.core_resp_v_o, bus.snoop_resp_v_o}, {exp_cv, exp_sv}); end
      if (exp_cv) begin
        n_vec++; if ({bus.core_hit_o, bus.core_state_o} !== {cq[0].hit, cq[0].st}) begin n_err++; $display("FAIL rnd_core_resp[%0d] got %b want %b", cyc, {bus.core_hit_o, bus.core_state_o}, {cq[0].hit, cq[0].st}); end
      end
      if (exp_sv) begin
        n_vec++; if ({bus.snoop_hit_o, bus.snoop_state_o} !== {sq[0].hit, sq[0].st}) begin n_err++; $display("FAIL rnd_snoop_resp[%0d] got %b want %b", cyc, {bus.snoop_hit_o, bus.snoop_state_o}, {sq[0].hit, sq[0].st}); end
      end
      if (cpop) void'(cq.pop_front());
      if (spop) void'(sq.pop_front());
      if (c_acc && !cw) begin
        e.hit = hit_of(ref_mem[ci], ct); e.st = ref_mem[ci][WW-1:TW]; e.due = cyc + 2;
        cq.push_back(e);
      end
      if (s_acc) begin
        e.hit = hit_of(ref_mem[si], st); e.st = ref_mem[si][WW-1:TW]; e.due = cyc + 2;
        sq.push_back(e);
      end
      if (c_acc && cw) ref_mem[ci] = {cs, ct};
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_miss_and_unwritten();
    test_write_snoop_conflict();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
